seven_seg_scanner: RTL

- Time-multiplexed 4-digit seven-segment display driver for the dice game.
- Drives the 4:1 digit multiplexer's SELECT and consumes its 4-bit OUT as DIGIT.
- Decodes DIGIT to segments and drives the common anodes.
- Inserts a blanking guard at every digit change to suppress ghosting.

---
 rtl/seven_seg_scanner_if.sv | 21 ++
 rtl/seven_seg_scanner.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side signal bundle for seven_seg_scanner: digit value and enables in,
// multiplexer select plus active-low anode/segment/decimal-point drives out.
interface seven_seg_scanner_if;
    logic [3:0] digit;
    logic [3:0] digit_en;
    logic [3:0] dp_in;
    logic [1:0] select;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        input  digit, digit_en, dp_in,
        output select, an, seg, dp
    );

    modport slave (
        output digit, digit_en, dp_in,
        input  select, an, seg, dp
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver with a blanking guard per slot.
// Optional leading-zero blanking is compiled in with `define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_scanner_if.master  bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [1:0]    select_q, select_nx;
    logic [3:0]    an_q, an_nx;
    logic [6:0]    seg_q, seg_nx;
    logic          dp_q, dp_nx;
    logic          wrap;
    logic          lz_hide;

    function automatic logic [6:0] decode(input logic [3:0] value);
        case (value)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q + 1'b1;
        select_nx = select_q;
        an_nx     = 4'b1111;
        seg_nx    = 7'b1111111;
        dp_nx     = 1'b1;
        wrap      = (cnt_q == LAST_CNT);

        if (wrap) begin
            cnt_nx    = '0;
            select_nx = select_q - 2'd1;
            state_nx  = BLANK;
        end else if (cnt_nx == BLANK_END) begin
            state_nx = SHOW;
        end

        // Outputs are computed from the next state so they register in step with it.
        if (state_nx == SHOW) begin
            seg_nx = decode(bus.digit);
            if (bus.digit_en[select_q] && !lz_hide) begin
                an_nx = ~(4'b0001 << select_q);
                dp_nx = ~bus.dp_in[select_q];
            end
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic lz_q, lz_nx;

    always_comb begin
        lz_nx   = lz_q;
        lz_hide = lz_q && (bus.digit == 4'h0) && (select_q != 2'd0);
        if (wrap && (select_nx == 2'd3)) begin
            lz_nx = 1'b1;
        end else if ((state_q == BLANK) && (state_nx == SHOW) &&
                     bus.digit_en[select_q] && (bus.digit != 4'h0)) begin
            lz_nx = 1'b0;
        end
    end

    // Reset starts a digit-3 slot, so the flag comes out of reset armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lz_q <= 1'b1;
        else        lz_q <= lz_nx;
    end
`else
    assign lz_hide = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_nx;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            select_q <= 2'd3;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_nx;
            select_q <= select_nx;
            an_q     <= an_nx;
            seg_q    <= seg_nx;
            dp_q     <= dp_nx;
        end
    end

    assign bus.select = select_q;
    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
    assign bus.dp     = dp_q;

endmodule
